// File: rtl/riscv_pkg.sv
`default_nettype none
// ==========================================================================
// riscv_pkg - shared RV32I constants and the {pc, instr} packet sent to decode
// Rev 1.0
// ==========================================================================
package riscv_pkg;

   localparam int              XLEN      = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ==========================================================================
// fetch_fifo - synchronous FIFO with flush, occupancy count and full/empty
// Rev 1.0
// ==========================================================================
module fetch_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(push && !flush && full && !do_pop))
            else $error("fetch_fifo overflow");
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ==========================================================================
// instr_fetch_unit - RV32I fetch front end: PC, imem requests, decode buffer
// Rev 1.0
// ==========================================================================
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
   localparam int               PKT_W   = $bits(fetch_pkt_t);

   logic [XLEN-1:0]  fetch_pc;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] inflight_nxt;
   logic [CNT_W-1:0] drop;
   logic [CNT_W:0]   occupancy;

   logic [CNT_W-1:0] tag_count;
   logic             tag_full;
   logic             tag_empty;
   logic [XLEN-1:0]  tag_pc;

   logic [CNT_W-1:0] buf_count;
   logic             buf_full;
   logic             buf_empty;
   fetch_pkt_t       buf_in;
   fetch_pkt_t       buf_head;

   logic             credit_ok;
   logic             accept;
   logic             rsp_keep;
   logic             if_pop;

   assign if_pop = if_valid && if_ready && !redirect_valid;

   // The entry decode takes this cycle frees its slot for a request issued in
   // the same cycle, which is what sustains one instruction per cycle.
   assign occupancy = {1'b0, inflight} + {1'b0, buf_count} - {{CNT_W{1'b0}}, if_pop};
   assign credit_ok = occupancy < {1'b0, DEPTH_C};

   assign imem_req_valid = rst && credit_ok && !tag_full && !redirect_valid;
   assign imem_req_addr  = fetch_pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign rsp_keep     = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign inflight_nxt = inflight + {{(CNT_W-1){1'b0}}, accept}
                                  - {{(CNT_W-1){1'b0}}, imem_rsp_valid};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (redirect_valid) begin
            // Everything still outstanding belongs to the abandoned path.
            fetch_pc <= align_word(redirect_pc);
            drop     <= inflight_nxt;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (BUF_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (accept),
      .din   (fetch_pc),
      .pop   (imem_rsp_valid && !tag_empty),
      .dout  (tag_pc),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   assign buf_in = '{pc: tag_pc, instr: imem_rsp_data};

   fetch_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (BUF_DEPTH)
   ) u_instr_buf (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (rsp_keep),
      .din   (buf_in),
      .pop   (if_pop),
      .dout  (buf_head),
      .count (buf_count),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign if_valid = !buf_empty;
   assign if_pc    = buf_empty ? '0        : buf_head.pc;
   assign if_instr = buf_empty ? INSTR_NOP : buf_head.instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         assert (inflight == tag_count)
            else $error("in-flight counter out of step with PC tags");
         assert (!(rsp_keep && buf_full && !if_pop))
            else $error("instruction buffer overflow");
      end
   end

endmodule
`default_nettype wire
